// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: schedules line rewrites and single-character updates
// onto the LCD driver's strobe interface. Line rewrites take priority over
// the character FIFO, and strobes are paced by lcd_busy and a GAP-cycle hold.
// Optional macro LCD_ARB_STATS_EN adds a saturating drop_count output.
module lcd_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       line_req,
    input  logic [63:0]                line_in,
    input  logic [63:0]                next_line_in,
    input  logic                       char_req,
    input  logic [3:0]                 char_idx,
    input  logic                       lcd_busy,
    output logic                       wLineEn,
    output logic                       wEn,
    output logic [3:0]                 charNum,
    output logic [63:0]                lineIn,
    output logic [63:0]                nextLineIn,
    output logic                       line_pending,
    output logic [$clog2(DEPTH+1)-1:0] char_count,
    output logic                       char_full
`ifdef LCD_ARB_STATS_EN
    ,
    output logic [7:0]                 drop_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int HW = $clog2(GAP);

    typedef enum logic [1:0] {
        IDLE,
        STROBE_LINE,
        STROBE_CHAR,
        HOLD
    } state_t;

    state_t         state, next_state;
    logic [3:0]     fifo [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [63:0]    line_buf, next_buf;
    logic [HW-1:0]  hold_cnt;
    logic           push, pop, drop;

    assign char_full = (char_count == CW'(DEPTH));

    // A flush can empty the FIFO on the very edge STROBE_CHAR is entered,
    // so the pop is qualified by occupancy rather than by state alone.
    assign pop  = (state == STROBE_CHAR) && (char_count != '0);
    assign push = char_req && !line_req && (!char_full || pop);
    assign drop = char_req && !line_req && char_full && !pop;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state selection: line beats chars, busy only gates IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!lcd_busy) begin
                    if (line_pending)            next_state = STROBE_LINE;
                    else if (char_count != '0)   next_state = STROBE_CHAR;
                end
            end
            STROBE_LINE: next_state = HOLD;
            STROBE_CHAR: next_state = pop ? HOLD : IDLE;
            HOLD: begin
                if (hold_cnt == HW'(GAP - 2)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Hold counter measures the GAP-1 cycles spent in HOLD
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              hold_cnt <= '0;
        else if (state != HOLD) hold_cnt <= '0;
        else                    hold_cnt <= hold_cnt + 1'b1;
    end

    // FIFO pointers and occupancy; line_req flushes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            char_count <= '0;
        end else if (line_req) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            char_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            char_count <= char_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= char_idx;
    end

    // Line buffers and pending flag; a fresh line_req keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_buf     <= '0;
            next_buf     <= '0;
            line_pending <= 1'b0;
        end else if (line_req) begin
            line_buf     <= line_in;
            next_buf     <= next_line_in;
            line_pending <= 1'b1;
        end else if (state == STROBE_LINE) begin
            line_pending <= 1'b0;
        end
    end

    // Registered strobes and held data to the driver
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wLineEn    <= 1'b0;
            wEn        <= 1'b0;
            charNum    <= '0;
            lineIn     <= '0;
            nextLineIn <= '0;
        end else begin
            wLineEn <= (state == STROBE_LINE);
            wEn     <= pop;
            if (state == STROBE_LINE) begin
                lineIn     <= line_buf;
                nextLineIn <= next_buf;
            end
            if (pop) charNum <= fifo[rd_ptr];
        end
    end

`ifdef LCD_ARB_STATS_EN
    // Saturating count of char requests dropped on a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          drop_count <= '0;
        else if (drop && drop_count != '1)  drop_count <= drop_count + 1'b1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_lcd_write_arbiter.sv
module tb_lcd_write_arbiter;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          line_req, char_req, lcd_busy;
    logic [63:0]   line_in, next_line_in;
    logic [3:0]    char_idx;
    logic          wLineEn, wEn, line_pending, char_full;
    logic [3:0]    charNum;
    logic [63:0]   lineIn, nextLineIn;
    logic [CW-1:0] char_count;
`ifdef LCD_ARB_STATS_EN
    logic [7:0]    drop_count;
`endif

    lcd_write_arbiter #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .reset(reset),
        .line_req(line_req), .line_in(line_in), .next_line_in(next_line_in),
        .char_req(char_req), .char_idx(char_idx), .lcd_busy(lcd_busy),
        .wLineEn(wLineEn), .wEn(wEn), .charNum(charNum),
        .lineIn(lineIn), .nextLineIn(nextLineIn),
        .line_pending(line_pending), .char_count(char_count), .char_full(char_full)
`ifdef LCD_ARB_STATS_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected strobes in issue order
    typedef struct {
        bit         is_line;
        logic [3:0] idx;
        logic [63:0] l;
        logic [63:0] n;
    } exp_t;
    exp_t sb[$];

    // Transaction-level model: pending line plus a bounded char queue
    logic [3:0]  mq[$];
    bit          m_pend = 0;
    logic [63:0] m_line = '0, m_next = '0;
    int          m_drop = 0;

    // Monitor: compares every strobe against the scoreboard and checks spacing
    exp_t        e;
    bit          have_last = 0;
    int unsigned last_cyc = 0;
    always @(negedge clk) begin
        if (reset) begin
            have_last = 0;
        end else if (wEn || wLineEn) begin
            check("strobe_exclusive", 64'(wEn && wLineEn), 0);
            if (have_last) check("strobe_spacing", 64'((cyc - last_cyc) >= GAP + 1), 1);
            have_last = 1;
            last_cyc  = cyc;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'({wLineEn, wEn}), 0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", 64'(wLineEn), 64'(e.is_line));
                if (e.is_line) begin
                    check("lineIn", lineIn, e.l);
                    check("nextLineIn", nextLineIn, e.n);
                end else begin
                    check("charNum", 64'(charNum), 64'(e.idx));
                end
            end
        end
    end

    function automatic exp_t mk_char(input logic [3:0] idx);
        exp_t x;
        x.is_line = 0; x.idx = idx; x.l = '0; x.n = '0;
        return x;
    endfunction

    // Each op task is entered at a negedge and returns at the next one
    task automatic do_char(input logic [3:0] idx);
        char_req = 1; char_idx = idx;
        if (mq.size() < DEPTH) mq.push_back(idx);
        else if (m_drop < 255) m_drop++;
        @(negedge clk);
        char_req = 0;
    endtask

    task automatic do_line(input logic [63:0] a, input logic [63:0] b);
        line_req = 1; line_in = a; next_line_in = b;
        m_pend = 1; m_line = a; m_next = b; mq.delete();
        @(negedge clk);
        line_req = 0;
    endtask

    task automatic do_both(input logic [63:0] a, input logic [63:0] b, input logic [3:0] idx);
        char_req = 1; char_idx = idx;
        line_req = 1; line_in = a; next_line_in = b;
        m_pend = 1; m_line = a; m_next = b; mq.delete();
        @(negedge clk);
        char_req = 0; line_req = 0;
    endtask

    task automatic check_status();
        check("char_count", 64'(char_count), 64'(mq.size()));
        check("char_full", 64'(char_full), 64'(mq.size() == DEPTH));
        check("line_pending", 64'(line_pending), 64'(m_pend));
`ifdef LCD_ARB_STATS_EN
        check("drop_count", 64'(drop_count), 64'(m_drop));
`endif
    endtask

    // Hand the model's backlog to the scoreboard, then let the DUT drain it
    task automatic drain(input bit rand_busy);
        exp_t x;
        if (m_pend) begin
            x.is_line = 1; x.idx = '0; x.l = m_line; x.n = m_next;
            sb.push_back(x);
        end
        foreach (mq[i]) sb.push_back(mk_char(mq[i]));
        mq.delete();
        m_pend = 0;
        for (int i = 0; i < 300; i++) begin
            lcd_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        lcd_busy = 0;
        check("drain_complete", 64'(sb.size()), 0);
        sb.delete();
        repeat (GAP + 3) @(negedge clk);
        check_status();
    endtask

    // Single char with busy low: strobe must appear after the third edge
    task automatic lat_char(input logic [3:0] idx);
        sb.push_back(mk_char(idx));
        char_req = 1; char_idx = idx;
        @(negedge clk);
        char_req = 0;
        check("lat_edge0_wEn", 64'(wEn), 0);
        @(negedge clk);
        check("lat_edge1_wEn", 64'(wEn), 0);
        @(negedge clk);
        check("lat_edge2_wEn", 64'(wEn), 1);
        check("lat_count_after_pop", 64'(char_count), 0);
        @(negedge clk);
        check("lat_single_cycle", 64'(wEn), 0);
        repeat (GAP + 2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        reset = 1; line_req = 0; char_req = 0; lcd_busy = 0;
        line_in = '0; next_line_in = '0; char_idx = '0;
        repeat (3) @(negedge clk);
        check("rst_wEn", 64'(wEn), 0);
        check("rst_wLineEn", 64'(wLineEn), 0);
        check("rst_lineIn", lineIn, 0);
        check("rst_charNum", 64'(charNum), 0);
        check_status();
        reset = 0;
        @(negedge clk);

        lat_char(4'd3);

        // Line rewrite flushes earlier chars; later char follows the line
        lcd_busy = 1;
        do_char(4'd1);
        do_char(4'd2);
        do_line(64'h747970696e670000, 64'h0123456789abcdef);
        do_char(4'd5);
        check_status();
        drain(0);

        // Overflow: only the first DEPTH chars survive
        lcd_busy = 1;
        for (int i = 0; i < 6; i++) do_char(4'(i));
        check_status();
        drain(0);

        // Latest line wins
        lcd_busy = 1;
        do_line(64'hAAAA_0000_AAAA_0000, 64'h1111_2222_3333_4444);
        do_line(64'hBBBB_5555_BBBB_5555, 64'h5555_6666_7777_8888);
        check_status();
        drain(0);

        // Long busy: nothing issues until one edge after busy falls
        lcd_busy = 1;
        do_char(4'd9);
        repeat (20) @(negedge clk);
        check("busy_no_strobe", 64'({wEn, wLineEn}), 0);
        mq.delete();
        sb.push_back(mk_char(4'd9));
        lcd_busy = 0;
        @(negedge clk);
        check("busy_fall_edge0", 64'(wEn), 0);
        @(negedge clk);
        check("busy_fall_edge1", 64'(wEn), 1);
        repeat (GAP + 3) @(negedge clk);
        check_status();

        // Reset in the middle of a strobe with a char still queued
        sb.push_back(mk_char(4'd7));
        char_req = 1; char_idx = 4'd7;
        @(negedge clk);
        char_idx = 4'd8;
        @(negedge clk);
        char_req = 0;
        for (int i = 0; i < 10 && !wEn; i++) @(negedge clk);
        check("pre_reset_strobe", 64'(wEn), 1);
        #2 reset = 1;
        #1;
        check("rst_mid_wEn", 64'(wEn), 0);
        check("rst_mid_wLineEn", 64'(wLineEn), 0);
        check("rst_mid_count", 64'(char_count), 0);
        check("rst_mid_pending", 64'(line_pending), 0);
        sb.delete(); mq.delete(); m_pend = 0; m_drop = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        lat_char(4'd4);
        check_status();

        // Randomized bursts under busy, drained with random busy pacing
        for (int b = 0; b < 25; b++) begin
            lcd_busy = 1;
            for (int k = 0; k < int'($urandom_range(1, 10)); k++) begin
                r = 4'($urandom_range(0, 9));
                if (r < 2)       do_line({$urandom, $urandom}, {$urandom, $urandom});
                else if (r == 2) do_both({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
                else if (r == 3) @(negedge clk);
                else             do_char(4'($urandom));
            end
            check_status();
            drain(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Schedules all writes into the 4-bit LCD driver so several game-logic requesters can share its single strobe interface.
- Requesters are the mode sequencer (whole-line rewrites) and the keystroke path (single-character cursor updates).
- Buffers character updates in a small FIFO, gives line rewrites priority, and paces strobes against the driver's busy flag.

Parameters:
DEPTH, 4, char-request FIFO depth (power of 2, 2..16)
GAP, 2, minimum cycles between consecutive strobes, >=2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
line_req  in  1  one-cycle pulse: request rewrite of both lines
line_in  in  64  first-line bytes, sampled with line_req
next_line_in  in  64  second-line bytes, sampled with line_req
char_req  in  1  one-cycle pulse: request cursor char update
char_idx  in  4  character position, sampled with char_req
lcd_busy  in  1  driver busy; no strobe is issued while high
wLineEn  out  1  one-cycle line-rewrite strobe to driver
wEn  out  1  one-cycle char-write strobe to driver
charNum  out  4  position for wEn, held after strobe
lineIn  out  64  line data to driver, held after strobe
nextLineIn  out  64  second-line data, held after strobe
line_pending  out  1  line rewrite latched, not yet issued
char_count  out  $clog2(DEPTH+1)  FIFO occupancy
char_full  out  1  char_count == DEPTH

Behaviour:
- Reset (async, immediate): all outputs 0, FIFO empty, line buffers 0, FSM in IDLE. A strobe in flight is cut immediately.
- Line latch:
  - At the line_req edge: line_buf <= line_in, next_buf <= next_line_in, line_pending <= 1.
  - The FIFO is flushed at the same edge; a char_req on that edge is discarded.
  - A second line_req before issue overwrites the buffers; latest wins, only one strobe results.
- Char push: on char_req with no line_req, push char_idx if not full. If full, the request is dropped and FIFO contents are unchanged.
- Push and pop on the same edge: occupancy is unchanged, and a push into a full FIFO with a simultaneous pop is accepted.
- FSM states: IDLE, STROBE_LINE, STROBE_CHAR, HOLD.
  - IDLE with lcd_busy high: stay in IDLE.
  - IDLE, not busy, line_pending set: go to STROBE_LINE.
  - IDLE, not busy, no line pending, char_count > 0: go to STROBE_CHAR.
  - STROBE_LINE: wLineEn = 1 for exactly one cycle. lineIn/nextLineIn come from the buffers, registered the same edge. line_pending clears unless line_req is sampled on that edge. Then go to HOLD.
  - STROBE_CHAR: wEn = 1 for exactly one cycle, charNum = FIFO head, pop. Then go to HOLD.
  - HOLD: count GAP-1 cycles, then go to IDLE.
- Strobes are registered outputs; wLineEn and wEn are never high together.
- Latency: request sampled at edge N with FSM idle and lcd_busy low → strobe high for the cycle after edge N+2.
- Priority is fixed: a pending line always beats queued chars. Chars pushed after line_req survive the line strobe and issue afterwards in FIFO order.
- Minimum spacing between strobe rising edges is GAP+1 cycles.
- Counters wrap modulo their width; FIFO pointers are log2(DEPTH) bits with a separate occupancy count.

Optional Feature:
Macro LCD_ARB_STATS_EN.
- Defined: adds output drop_count [7:0], reset 0.
  - Increments on each char_req dropped because the FIFO is full.
  - Saturates at 255; it does not count line-flush discards.
  - Cleared by reset only.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Assert reset mid-strobe → wEn/wLineEn drop to 0 the same cycle; char_count=0, line_pending=0, FSM accepts new requests 1 cycle after release.
- char_req idx=3, lcd_busy=0 → wEn high exactly one cycle, charNum=3, three edges after request; char_count returns to 0.
- Push idx 1,2 then line_req line_in=64'h747970696e670000, then char_req 5 → single wLineEn with lineIn matching; idx 1,2 never issued; wEn with charNum=5 follows ≥GAP+1 cycles later.
- DEPTH=4, lcd_busy=1, six char_req idx 0..5 → char_full=1, only 0..3 issued in order after busy falls; drop_count=2 with LCD_ARB_STATS_EN.
- Two line_req pulses (A then B) while lcd_busy=1 → after busy falls exactly one wLineEn, lineIn=B.
- lcd_busy held high 20 cycles with pending work → no strobe; first strobe is the cycle after edge following busy fall+1.
